hazard_control_unit: RTL

//  Pipeline sequencer that works alongside the forwarding logic. It detects

---
 rtl/hazard_control_unit.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//
// Purpose:
//   Pipeline sequencer that works alongside the forwarding network. It
//   handles three jobs:
//     - inserts bubbles for load-use hazards that forwarding cannot cover;
//     - freezes the front of the pipe while a multi-cycle EX operation runs,
//       with a watchdog that forces an exit;
//     - flushes IF/ID and ID/EX when a branch resolved in EX is taken.
//   Control outputs are combinational from the state and inputs. Only the
//   FSM state, the shared wait counter and the mc_timeout pulse are registered.
//
// Parameters:
//   LOAD_STALL_CYCLES : bubbles inserted per load-use hazard (1..4)
//   MC_TIMEOUT        : max MC_WAIT cycles before forced exit (>=2)
//
// Ports:
//   clk, rst                    : clock (rising edge), async active-high reset
//   rs1_id, rs2_id              : source register addresses of the ID instr
//   uses_rs1_id, uses_rs2_id    : ID instruction actually reads rs1 / rs2
//   rd_ex, MemRead_ex           : destination address / is-load flag in EX
//   branch_taken_ex             : branch/jump in EX resolved taken
//   mc_start_ex, mc_done        : multi-cycle op start pulse / result valid
//   pc_write, ifid_write        : PC and IF/ID enables
//   ifid_flush, idex_bubble     : clear IF/ID, inject NOP into ID/EX
//   ex_hold, exmem_bubble       : freeze ID/EX + EX inputs, NOP into EX/MEM
//   mc_timeout                  : registered 1-cycle pulse on watchdog exit
//   state                       : 00 RUN, 01 LD_STALL, 10 MC_WAIT
//
// Optional feature (macro HAZARD_PERF_CNT_EN):
//   stall_cycles [31:0] : saturating count of cycles with pc_write=0
//   flush_count  [31:0] : saturating count of ifid_flush cycles in RUN or
//                         LD_STALL
//   Both clear on rst. Without the macro these ports and their logic are
//   absent.
// -----------------------------------------------------------------------------

// Simulation-only checker: flags illegal input combinations and illegal states.
module hazard_control_unit_chk (
  input logic       clk,
  input logic       rst,
  input logic       mc_start_ex,
  input logic       branch_taken_ex,
  input logic [1:0] state
);

  // mc_start_ex and branch_taken_ex must never arrive together
  a_no_start_with_branch: assert property (
    @(posedge clk) disable iff (rst) !(mc_start_ex && branch_taken_ex)
  ) else $error("hazard_control_unit: mc_start_ex with branch_taken_ex");

  // the unused encoding 2'b11 must never be reached
  a_legal_state: assert property (
    @(posedge clk) disable iff (rst) (state != 2'b11)
  ) else $error("hazard_control_unit: illegal state encoding");

endmodule

module hazard_control_unit #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MC_TIMEOUT        = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       uses_rs1_id,
  input  logic       uses_rs2_id,
  input  logic [4:0] rd_ex,
  input  logic       MemRead_ex,
  input  logic       branch_taken_ex,
  input  logic       mc_start_ex,
  input  logic       mc_done,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       ex_hold,
  output logic       exmem_bubble,
  output logic       mc_timeout,
  output logic [1:0] state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  // One counter serves both wait states, so it is sized for the larger range.
  localparam int CNT_W = $clog2(MC_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LD_LAST  = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] MC_LAST  = CNT_W'(MC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LD_STALL = 2'b01,
    ST_MC_WAIT  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mc_timeout_q, mc_timeout_d;
  logic             load_use_s;

  // A load whose destination is read by the ID instruction; x0 never hazards.
  assign load_use_s = MemRead_ex && (rd_ex != 5'd0) &&
                      ((uses_rs1_id && (rd_ex == rs1_id)) ||
                       (uses_rs2_id && (rd_ex == rs2_id)));

  // State register, shared wait counter and watchdog pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      cnt_q        <= CNT_ZERO;
      mc_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mc_timeout_q <= mc_timeout_d;
    end
  end

  // Next-state logic and combinational pipeline controls.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mc_timeout_d = 1'b0;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    ex_hold      = 1'b0;
    exmem_bubble = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mc_start_ex) begin
          // Multi-cycle start outranks everything, including a taken branch.
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          ex_hold      = 1'b1;
          exmem_bubble = 1'b1;
          state_d      = ST_MC_WAIT;
          cnt_d        = CNT_ZERO;
        end else if (branch_taken_ex) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (load_use_s) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          // This cycle is the first bubble; extra bubbles come from LD_STALL.
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = ST_LD_STALL;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_LD_STALL: begin
        if (branch_taken_ex) begin
          // The stalled ID instruction is on the wrong path: flush it and
          // let the PC take the branch target.
          pc_write    = 1'b1;
          ifid_write  = 1'b0;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_d     = ST_RUN;
          cnt_d       = CNT_ZERO;
        end else begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (cnt_q == LD_LAST) begin
            state_d = ST_RUN;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      ST_MC_WAIT: begin
        // EX is frozen here, so branch_taken_ex cannot be genuine and is ignored.
        if (mc_done) begin
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          ex_hold      = 1'b1;
          exmem_bubble = 1'b1;
          if (cnt_q == MC_LAST) begin
            // Watchdog: the MC_TIMEOUT-th wait cycle without a result.
            state_d      = ST_RUN;
            cnt_d        = CNT_ZERO;
            mc_timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        // Unreachable encoding: squash the front end and recover to RUN.
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        state_d     = ST_RUN;
        cnt_d       = CNT_ZERO;
      end
    endcase

    // Reset is asynchronous, so the controls switch to their reset values
    // without waiting for a clock edge.
    if (rst) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      ex_hold      = 1'b0;
      exmem_bubble = 1'b0;
    end else begin
      pc_write     = pc_write;
      ifid_write   = ifid_write;
    end
  end

  assign mc_timeout = mc_timeout_q;
  assign state      = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;
  logic        flush_in_scope_s;

  assign flush_in_scope_s = ifid_flush &&
                            ((state_q == ST_RUN) || (state_q == ST_LD_STALL));

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if (!pc_write && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (flush_in_scope_s && (flush_count_q != 32'hFFFF_FFFF)) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

  hazard_control_unit_chk u_chk (
    .clk             (clk),
    .rst             (rst),
    .mc_start_ex     (mc_start_ex),
    .branch_taken_ex (branch_taken_ex),
    .state           (state)
  );

endmodule
